// File: rtl/mult_sched.sv
// mult_sched
//   Sequencer and two-port round-robin arbiter in front of the shared 128-bit
//   SIMD unsigned multiplier. It accepts one request from one of two requesters
//   and registers the winner's operands. It drives the external combinational
//   multiplier for one cycle (EXEC) and captures the product. The product is
//   then held on the response port until the consumer takes it (RESP).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid[i], req_ready[i] request handshake for requester i
//                              (req_ready is combinational, one-hot or zero)
//   req_a*/req_b*              128-bit operands per requester
//   req_ww*                    element width (`w8 = 2'b00, `w16 = 2'b01)
//   req_tag*                   opaque tag returned with the response
//   mul_a/mul_b/mul_ctrl_ww    registered drive to the external multiplier
//                              (mul_ctrl_ww: 2'b01 = 8-bit, 2'b10 = 16-bit)
//   mul_result                 combinational product from the multiplier
//   rsp_valid/rsp_ready        response handshake
//   rsp_result/id/tag/err      registered response payload
//
// Bit numbering
//   Data is architecturally numbered from the MSB (bit 0 = MSB). Vectors here
//   are declared descending, so architectural bit i is RTL bit [127-i] and
//   lane 0 is the most significant lane. req_valid and req_ready are indexed
//   by requester number.
//
// Configuration
//   MULT_SCHED_ODD_EN: adds req_odd0/req_odd1. When the winner's odd bit is
//   set, both operands are captured shifted toward the MSB by one element
//   (8 bits for `w8, 16 bits for `w16), zero filled. The multiplier therefore
//   works on the odd elements.
module mult_sched #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [127:0]     req_a0,
  input  logic [127:0]     req_a1,
  input  logic [127:0]     req_b0,
  input  logic [127:0]     req_b1,
  input  logic [1:0]       req_ww0,
  input  logic [1:0]       req_ww1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
`ifdef MULT_SCHED_ODD_EN
  input  logic             req_odd0,
  input  logic             req_odd1,
`endif
  output logic [127:0]     mul_a,
  output logic [127:0]     mul_b,
  output logic [1:0]       mul_ctrl_ww,
  input  logic [127:0]     mul_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [127:0]     rsp_result,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  localparam logic [1:0] WW_8  = 2'b00;
  localparam logic [1:0] WW_16 = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t           r_state;
  logic             r_prio;
  logic [127:0]     r_a;
  logic [127:0]     r_b;
  logic [1:0]       r_ww;
  logic [1:0]       r_ctrl_ww;
  logic [TAG_W-1:0] r_tag;
  logic             r_id;
  logic [127:0]     r_result;
  logic             r_err;
  logic             r_valid;

  logic             w_any;
  logic             w_grant;
  logic [1:0]       w_req_ready;
  logic [127:0]     w_sel_a;
  logic [127:0]     w_sel_b;
  logic [1:0]       w_sel_ww;
  logic [TAG_W-1:0] w_sel_tag;
  logic [127:0]     w_cap_a;
  logic [127:0]     w_cap_b;
  logic             w_ww_ok;

  // Only the two encodings the multiplier understands are legal.
  function automatic logic f_ww_legal(input logic [1:0] ww);
    logic ok;
    case (ww)
      WW_8, WW_16: ok = 1'b1;
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

`ifdef MULT_SCHED_ODD_EN
  // Move odd elements into the even slots the multiplier consumes.
  function automatic logic [127:0] f_odd_align(input logic [127:0] v,
                                               input logic [1:0]   ww,
                                               input logic         odd);
    logic [127:0] r;
    if (!odd) begin
      r = v;
    end else begin
      case (ww)
        WW_8:    r = v << 7'd8;
        WW_16:   r = v << 7'd16;
        default: r = v;
      endcase
    end
    return r;
  endfunction
`endif

  // Round-robin pick and mux of the winner's payload.
  always_comb begin
    w_any = |req_valid;
    if (req_valid[r_prio]) begin
      w_grant = r_prio;
    end else begin
      w_grant = ~r_prio;
    end
    if (w_grant) begin
      w_sel_a   = req_a1;
      w_sel_b   = req_b1;
      w_sel_ww  = req_ww1;
      w_sel_tag = req_tag1;
    end else begin
      w_sel_a   = req_a0;
      w_sel_b   = req_b0;
      w_sel_ww  = req_ww0;
      w_sel_tag = req_tag0;
    end
  end

`ifdef MULT_SCHED_ODD_EN
  logic w_sel_odd;
  assign w_sel_odd = w_grant ? req_odd1 : req_odd0;
  assign w_cap_a   = f_odd_align(w_sel_a, w_sel_ww, w_sel_odd);
  assign w_cap_b   = f_odd_align(w_sel_b, w_sel_ww, w_sel_odd);
`else
  assign w_cap_a   = w_sel_a;
  assign w_cap_b   = w_sel_b;
`endif

  // Accept strobe: only in IDLE, and held low while reset is asserted so the
  // port shows its reset value even if requesters keep valid high.
  always_comb begin
    w_req_ready = 2'b00;
    if (rst_n && (r_state == ST_IDLE) && w_any) begin
      w_req_ready[w_grant] = 1'b1;
    end else begin
      w_req_ready = 2'b00;
    end
  end

  assign w_ww_ok = f_ww_legal(r_ww);

  // Sequencer FSM with all datapath and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_prio    <= 1'b0;
      r_a       <= 128'd0;
      r_b       <= 128'd0;
      r_ww      <= 2'b00;
      r_ctrl_ww <= 2'b00;
      r_tag     <= {TAG_W{1'b0}};
      r_id      <= 1'b0;
      r_result  <= 128'd0;
      r_err     <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_a       <= w_cap_a;
            r_b       <= w_cap_b;
            r_ww      <= w_sel_ww;
            // multiplier encoding is the request encoding plus one
            r_ctrl_ww <= w_sel_ww + 2'b01;
            r_tag     <= w_sel_tag;
            r_id      <= w_grant;
            r_prio    <= ~w_grant;
            r_state   <= ST_EXEC;
          end else begin
            r_state   <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (w_ww_ok) begin
            r_result <= mul_result;
          end else begin
            r_result <= 128'd0;
          end
          r_err   <= ~w_ww_ok;
          r_valid <= 1'b1;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RESP;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = w_req_ready;
  assign mul_a       = r_a;
  assign mul_b       = r_b;
  assign mul_ctrl_ww = r_ctrl_ww;
  assign rsp_valid   = r_valid;
  assign rsp_result  = r_result;
  assign rsp_id      = r_id;
  assign rsp_tag     = r_tag;
  assign rsp_err     = r_err;

endmodule
